// File: rtl/bht_local_hist_predictor.sv
// -----------------------------------------------------------------------------
// bht_local_hist_predictor
//
// Local-history branch history table. Each row holds a valid bit, a HIST_LEN-bit
// local history and 2**HIST_LEN two-bit saturating counters. The row is selected
// by PC bits [PC_OFFSET+ROW_BITS-1 : PC_OFFSET]. There is no tag, so rows can
// alias. The history of the row selects one counter, and the MSB of that counter
// gives the predicted direction.
//
// Ports
//   clk_i           core clock
//   rst_ni          synchronous, active-low reset
//   flush_i         clears every row in one cycle; drops a same-cycle update
//   debug_mode_i    suppresses updates (lookups still served)
//   lookup_valid_i  lookup request this cycle
//   lookup_pc_i     PC to predict
//   pred_valid_o    registered: previous-cycle lookup hit a valid row
//   pred_taken_o    registered: predicted direction
//   update_valid_i  resolved conditional branch this cycle
//   update_pc_i     PC of the resolved branch
//   update_taken_i  resolved direction
// -----------------------------------------------------------------------------
module bht_local_hist_predictor #(
  parameter int unsigned NR_ENTRIES = 128,
  parameter int unsigned HIST_LEN   = 3,
  parameter int unsigned VLEN       = 32,
  parameter int unsigned PC_OFFSET  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            update_valid_i,
  input  logic [VLEN-1:0] update_pc_i,
  input  logic            update_taken_i
);

  localparam int unsigned ROW_BITS = $clog2(NR_ENTRIES);
  localparam int unsigned NUM_CTR  = 2 ** HIST_LEN;
  localparam int unsigned IDX_MSB  = PC_OFFSET + ROW_BITS - 1;

  logic [ROW_BITS-1:0] lookup_idx;
  logic [ROW_BITS-1:0] update_idx;

  assign lookup_idx = lookup_pc_i[IDX_MSB:PC_OFFSET];
  assign update_idx = update_pc_i[IDX_MSB:PC_OFFSET];

  // PC bits outside the index field are ignored on purpose (untagged table).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[VLEN-1:IDX_MSB+1], lookup_pc_i[PC_OFFSET-1:0],
                            update_pc_i[VLEN-1:IDX_MSB+1], update_pc_i[PC_OFFSET-1:0]};

  // Row views, driven from the per-row storage below.
  logic                     row_valid [NR_ENTRIES];
  logic [HIST_LEN-1:0]      row_hist  [NR_ENTRIES];
  logic [NUM_CTR-1:0][1:0]  row_ctr   [NR_ENTRIES];

  // ---------------------------------------------------------------------------
  // Update path: the new row contents are computed once from the addressed row.
  // Each row then only has to decode its own write enable.
  // ---------------------------------------------------------------------------
  logic                    update_en;
  logic                    upd_valid_cur;
  logic [HIST_LEN-1:0]     upd_hist_cur;
  logic [NUM_CTR-1:0][1:0] upd_ctr_cur;
  logic [1:0]              upd_sel_cur;
  logic [1:0]              upd_sel_next;
  logic [1:0]              alloc_ctr;
  logic [HIST_LEN-1:0]     upd_hist_next;
  logic [NUM_CTR-1:0][1:0] upd_ctr_next;

  assign update_en = update_valid_i & ~debug_mode_i & ~flush_i;

  always_comb begin
    upd_valid_cur = row_valid[update_idx];
    upd_hist_cur  = row_hist[update_idx];
    upd_ctr_cur   = row_ctr[update_idx];
    upd_sel_cur   = upd_ctr_cur[upd_hist_cur];
    upd_sel_next  = upd_sel_cur;
    alloc_ctr     = update_taken_i ? 2'b10 : 2'b01;
    upd_hist_next = {{(HIST_LEN-1){1'b0}}, update_taken_i};
    upd_ctr_next  = {NUM_CTR{alloc_ctr}};

    // The counter saturates at 0 and 3 and does not wrap.
    if (update_taken_i && (upd_sel_cur != 2'b11)) begin
      upd_sel_next = upd_sel_cur + 2'd1;
    end else if (!update_taken_i && (upd_sel_cur != 2'b00)) begin
      upd_sel_next = upd_sel_cur - 2'd1;
    end

    if (upd_valid_cur) begin
      upd_ctr_next               = upd_ctr_cur;
      upd_ctr_next[upd_hist_cur] = upd_sel_next;
      upd_hist_next              = {upd_hist_cur[HIST_LEN-2:0], update_taken_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Row storage. It is held in flops because flush has to clear the whole table
  // in a single cycle.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NR_ENTRIES; gi++) begin : g_row
      logic                    valid_reg;
      logic [HIST_LEN-1:0]     hist_reg;
      logic [NUM_CTR-1:0][1:0] ctr_reg;
      logic                    row_wr;

      assign row_wr = update_en && (update_idx == ROW_BITS'(gi));

      always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
          valid_reg <= 1'b0;
          hist_reg  <= '0;
          ctr_reg   <= {NUM_CTR{2'b01}};
        end else if (row_wr) begin
          valid_reg <= 1'b1;
          hist_reg  <= upd_hist_next;
          ctr_reg   <= upd_ctr_next;
        end
      end

      assign row_valid[gi] = valid_reg;
      assign row_hist[gi]  = hist_reg;
      assign row_ctr[gi]   = ctr_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Lookup path. The lookup reads state before this edge's write, so a
  // same-cycle update or flush is not visible to the prediction.
  // ---------------------------------------------------------------------------
  logic                    lk_valid;
  logic [HIST_LEN-1:0]     lk_hist;
  logic [NUM_CTR-1:0][1:0] lk_ctr;
  logic                    lk_taken;
  logic                    pred_valid_reg;
  logic                    pred_taken_reg;

  always_comb begin
    lk_valid = row_valid[lookup_idx];
    lk_hist  = row_hist[lookup_idx];
    lk_ctr   = row_ctr[lookup_idx];
    lk_taken = lk_ctr[lk_hist][1];
  end

  // Flush leaves this register alone; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pred_valid_reg <= 1'b0;
      pred_taken_reg <= 1'b0;
    end else if (lookup_valid_i) begin
      pred_valid_reg <= lk_valid;
      pred_taken_reg <= lk_valid & lk_taken;
    end else begin
      pred_valid_reg <= 1'b0;
      pred_taken_reg <= 1'b0;
    end
  end

  assign pred_valid_o = pred_valid_reg;
  assign pred_taken_o = pred_taken_reg;

endmodule

// File: tb/tb_bht_local_hist_predictor.sv
// -----------------------------------------------------------------------------
// tb_bht_local_hist_predictor
//
// Directed bench for bht_local_hist_predictor. A table model works with integer
// counters and histories and produces the expected registered prediction for
// every cycle. A negedge process compares the DUT against that model. Literal
// expectations worked out by hand pin both the DUT outputs and the model's own
// row state at the key points.
// -----------------------------------------------------------------------------
module tb_bht_local_hist_predictor;

  localparam logic [31:0] PA0  = 32'h8000_0000;
  localparam logic [31:0] P10  = 32'h8000_0010;
  localparam logic [31:0] P20  = 32'h8000_0020;
  localparam logic [31:0] P40  = 32'h8000_0040;
  localparam logic [31:0] P110 = 32'h8000_0110;
  localparam logic [31:0] P12  = 32'h8000_0012;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic        lookup_valid_i = 1'b0;
  logic [31:0] lookup_pc_i = '0;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic        update_valid_i = 1'b0;
  logic [31:0] update_pc_i = '0;
  logic        update_taken_i = 1'b0;

  always #5 clk_i = ~clk_i;

  bht_local_hist_predictor dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .debug_mode_i   (debug_mode_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_pc_i    (lookup_pc_i),
    .pred_valid_o   (pred_valid_o),
    .pred_taken_o   (pred_taken_o),
    .update_valid_i (update_valid_i),
    .update_pc_i    (update_pc_i),
    .update_taken_i (update_taken_i)
  );

  // ---------------- model ----------------
  int m_valid [128];
  int m_hist  [128];
  int m_ctr   [128][8];
  bit exp_valid = 1'b0;
  bit exp_taken = 1'b0;
  bit nxt_valid;
  bit nxt_taken;
  bit checking = 1'b0;

  function automatic int row_of(input logic [31:0] pc);
    return int'((pc / 2) % 128);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 128; r++) begin
      m_valid[r] = 0;
      m_hist[r]  = 0;
      for (int h = 0; h < 8; h++) m_ctr[r][h] = 1;
    end
  endtask

  // Applies the current inputs to the model, as the next clock edge will.
  task automatic model_edge();
    int r;
    int c;
    if (!rst_ni) begin
      model_clear();
      nxt_valid = 1'b0;
      nxt_taken = 1'b0;
    end else begin
      nxt_valid = 1'b0;
      nxt_taken = 1'b0;
      if (lookup_valid_i) begin
        r = row_of(lookup_pc_i);
        nxt_valid = (m_valid[r] != 0);
        nxt_taken = (m_valid[r] != 0) && (m_ctr[r][m_hist[r]] >= 2);
      end
      if (flush_i) begin
        model_clear();
      end else if (update_valid_i && !debug_mode_i) begin
        r = row_of(update_pc_i);
        if (m_valid[r] != 0) begin
          c = m_ctr[r][m_hist[r]] + (update_taken_i ? 1 : -1);
          if (c > 3) c = 3;
          if (c < 0) c = 0;
          m_ctr[r][m_hist[r]] = c;
          m_hist[r] = (m_hist[r] * 2 + (update_taken_i ? 1 : 0)) % 8;
        end else begin
          m_valid[r] = 1;
          m_hist[r]  = update_taken_i ? 1 : 0;
          for (int h = 0; h < 8; h++) m_ctr[r][h] = update_taken_i ? 2 : 1;
        end
      end
    end
  endtask

  // ---------------- counters and literal requests ----------------
  int    n_checks = 0;
  int    n_fail   = 0;
  int    lit_req  = 0;
  int    lit_ack  = 0;
  int    lit_kind;      // 0: prediction, 1: model counter, 2: model history
  string lit_name;
  bit    lit_v;
  bit    lit_t;
  int    pin_row;
  int    pin_h;
  int    pin_val;

  // Single compare process
  always @(negedge clk_i) begin
    if (checking) begin
      n_checks++;
      if (pred_valid_o !== exp_valid) begin
        n_fail++;
        $display("FAIL cycle pred_valid @%0t: got %b required %b", $time, pred_valid_o, exp_valid);
      end
      n_checks++;
      if (pred_taken_o !== exp_taken) begin
        n_fail++;
        $display("FAIL cycle pred_taken @%0t: got %b required %b", $time, pred_taken_o, exp_taken);
      end
      if (lit_req != lit_ack) begin
        lit_ack = lit_req;
        if (lit_kind == 0) begin
          n_checks++;
          if (pred_valid_o !== lit_v || pred_taken_o !== lit_t) begin
            n_fail++;
            $display("FAIL %s: got valid=%b taken=%b required valid=%b taken=%b",
                     lit_name, pred_valid_o, pred_taken_o, lit_v, lit_t);
          end
          n_checks++;
          if (exp_valid != lit_v || exp_taken != lit_t) begin
            n_fail++;
            $display("FAIL %s model: got valid=%b taken=%b required valid=%b taken=%b",
                     lit_name, exp_valid, exp_taken, lit_v, lit_t);
          end
        end else if (lit_kind == 1) begin
          n_checks++;
          if (m_ctr[pin_row][pin_h] != pin_val) begin
            n_fail++;
            $display("FAIL %s: row %0d ctr[%0d] got %0d required %0d",
                     lit_name, pin_row, pin_h, m_ctr[pin_row][pin_h], pin_val);
          end
        end else begin
          n_checks++;
          if (m_hist[pin_row] != pin_val) begin
            n_fail++;
            $display("FAIL %s: row %0d hist got %0d required %0d",
                     lit_name, pin_row, m_hist[pin_row], pin_val);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                      input logic [31:0] upc, input bit ut, input bit fl,
                      input bit dbg, input bit rst_n);
    lookup_valid_i = lv;
    lookup_pc_i    = lpc;
    update_valid_i = uv;
    update_pc_i    = upc;
    update_taken_i = ut;
    flush_i        = fl;
    debug_mode_i   = dbg;
    rst_ni         = rst_n;
    model_edge();
    @(posedge clk_i);
    exp_valid = nxt_valid;
    exp_taken = nxt_taken;
    checking  = 1'b1;
    #1;
    $display("txn lv=%b lpc=%h uv=%b upc=%h ut=%b fl=%b dbg=%b rst_n=%b -> exp v=%b t=%b",
             lv, lpc, uv, upc, ut, fl, dbg, rst_n, nxt_valid, nxt_taken);
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t);
    step(1'b0, '0, 1'b1, pc, t, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic lit(input string name, input bit v, input bit t);
    lit_kind = 0; lit_name = name; lit_v = v; lit_t = t;
    lit_req++;
    @(negedge clk_i);
    #1;
  endtask

  task automatic pin_ctr(input string name, input int row, input int h, input int val);
    lit_kind = 1; lit_name = name; pin_row = row; pin_h = h; pin_val = val;
    lit_req++;
    @(negedge clk_i);
    #1;
  endtask

  task automatic pin_hist(input string name, input int row, input int val);
    lit_kind = 2; lit_name = name; pin_row = row; pin_val = val;
    lit_req++;
    @(negedge clk_i);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_clear();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("reset_state", 1'b0, 1'b0);

    // T1
    look(PA0);
    lit("T1_lookup_after_reset", 1'b0, 1'b0);

    // T2: allocate taken -> hist=1, all counters 2
    upd(P10, 1'b1);
    look(P10);
    lit("T2_alloc_taken", 1'b1, 1'b1);
    pin_hist("T2_hist", 8, 1);
    pin_ctr("T2_ctr1", 8, 1, 2);

    // T3: three more taken -> hist 7, ctr[7]=3
    upd(P10, 1'b1);
    upd(P10, 1'b1);
    upd(P10, 1'b1);
    pin_hist("T3_hist7", 8, 7);
    pin_ctr("T3_ctr7", 8, 7, 3);
    upd(P10, 1'b1);
    pin_ctr("T3_sat3", 8, 7, 3);
    look(P10);
    lit("T3_no_wrap_high", 1'b1, 1'b1);
    upd(P10, 1'b0);
    pin_ctr("T3_dec", 8, 7, 2);
    pin_hist("T3_hist6", 8, 6);
    look(P10);
    lit("T3_ctr6_taken", 1'b1, 1'b1);

    // Saturation at 0 on row 16
    upd(P20, 1'b0);
    upd(P20, 1'b0);
    upd(P20, 1'b0);
    pin_ctr("T3_sat0", 16, 0, 0);
    look(P20);
    lit("T3_no_wrap_low", 1'b1, 1'b0);

    // T4: alias 0x...110 maps to row 8 (hist 6 -> ctr[6]=3, hist 5)
    upd(P10, 1'b1);
    pin_hist("T4_hist5", 8, 5);
    look(P110);
    lit("T4_alias", 1'b1, 1'b1);

    // T5: flush answers from pre-flush state, then same-cycle RBW
    step(1'b1, P10, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    lit("flush_reads_pre_state", 1'b1, 1'b1);
    look(P10);
    lit("flush_cleared", 1'b0, 1'b0);
    step(1'b1, P10, 1'b1, P10, 1'b1, 1'b0, 1'b0, 1'b1);
    lit("T5_rbw_pre_update", 1'b0, 1'b0);
    look(P10);
    lit("T5_update_kept", 1'b1, 1'b1);

    // T6: debug blocks updates only; flush drops same-cycle update
    step(1'b1, P10, 1'b1, P40, 1'b1, 1'b0, 1'b1, 1'b1);
    lit("T6_debug_lookup", 1'b1, 1'b1);
    look(P40);
    lit("T6_debug_blocked", 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, P40, 1'b1, 1'b1, 1'b0, 1'b1);
    look(P40);
    lit("T6_flush_drops_update", 1'b0, 1'b0);

    // Reset mid-stream discards the in-flight lookup and clears the table
    upd(P10, 1'b1);
    step(1'b1, P10, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("reset_discards_lookup", 1'b0, 1'b0);
    look(P10);
    lit("reset_cleared_row", 1'b0, 1'b0);

    // No lookup -> outputs return to zero
    upd(P12, 1'b0);
    look(P12);
    lit("lookup_hit_nt", 1'b1, 1'b0);
    idle();
    lit("no_lookup_zero", 1'b0, 1'b0);

    // Mixed traffic over a small set of aliasing PCs, checked against the model
    for (int i = 0; i < 80; i++) begin
      logic [31:0] pcs [6];
      pcs[0] = P10; pcs[1] = P20; pcs[2] = P110; pcs[3] = P40; pcs[4] = P12; pcs[5] = PA0;
      step(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
           1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0), 1'b1);
    end

    idle();
    @(negedge clk_i);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
